// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and encodings for the tristate bus arbiter.
package tri_bus_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_GRANT = 2'd1;
  localparam logic [1:0] ENC_TURN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    GRANT = ENC_GRANT,
    TURN  = ENC_TURN
  } state_t;

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface tri_bus_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] sel;
  logic                 busy;

  modport master (input req, output gnt, output sel, output busy);
  modport slave  (output req, input gnt, input sel, input busy);
endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [$clog2(N)-1:0] o_win_idx,
  output logic [N-1:0]         o_win_onehot,
  output logic                 o_any
);
  localparam int unsigned SW = $clog2(N);

  logic [SW-1:0] w_idx;
  logic          w_found;

  // Walk the request vector from ptr upward; the first hit wins.
  always_comb begin
    o_win_idx = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = SW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_win_idx = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  assign o_win_onehot = N'(1) << o_win_idx;
  assign o_any        = |i_req;

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared tristate bus with hold limit and
// forced all-off turnaround between owners.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  tri_bus_arbiter_if.master bus
);
  localparam int unsigned SW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic [SW-1:0] r_sel;
  logic          r_busy;
  logic [SW-1:0] r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic [TW-1:0] r_turn_cnt;

  logic [SW-1:0] w_win_idx;
  logic [N-1:0]  w_win_onehot;
  logic          w_any;
  logic [SW-1:0] w_next_ptr;
  logic          w_turn_last;
  logic          w_release;
  logic          w_arb;

  rr_pick #(.N(N)) u_rr_pick (
    .i_req        (bus.req),
    .i_ptr        (r_ptr),
    .o_win_idx    (w_win_idx),
    .o_win_onehot (w_win_onehot),
    .o_any        (w_any)
  );

  assign w_next_ptr  = (w_win_idx == SW'(N - 1)) ? '0 : w_win_idx + SW'(1);
  assign w_turn_last = (r_turn_cnt == TW'(TURNAROUND - 1));
  // Owner dropping req and hitting the hold limit together is one release.
  assign w_release   = !bus.req[r_sel] || (r_hold_cnt == HW'(MAX_HOLD - 1));
  // Arbitration happens only from IDLE or on the final turnaround cycle.
  assign w_arb       = w_any && ((r_state == IDLE) || ((r_state == TURN) && w_turn_last));

  // FSM with registered grant, owner index, busy flag, pointer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
    end else if (w_arb) begin
      r_state    <= GRANT;
      r_gnt      <= w_win_onehot;
      r_sel      <= w_win_idx;
      r_busy     <= 1'b1;
      r_ptr      <= w_next_ptr;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
        end
        GRANT: begin
          if (w_release) begin
            r_state    <= TURN;
            r_gnt      <= '0;
            r_turn_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        TURN: begin
          if (w_turn_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_turn_cnt <= r_turn_cnt + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, MAX_HOLD=8, TURNAROUND=1).
module tb_tri_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  tri_bus_arbiter_if #(.N(4)) u_if ();

  tri_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Invariants: grant one-hot-or-zero, owner changes separated by a zero cycle.
  logic [3:0] last_nz  = 4'b0000;
  int         zero_run = 0;
  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(u_if.gnt)) begin
      n_err++;
      $display("FAIL inv_onehot: gnt=%b not one-hot/zero", u_if.gnt);
    end
    if (u_if.gnt == 4'b0000) begin
      zero_run++;
    end else begin
      if (last_nz != 4'b0000 && u_if.gnt != last_nz) begin
        n_cmp++;
        if (zero_run < 1) begin
          n_err++;
          $display("FAIL inv_gap: gnt %b -> %b with %0d zero cycles, need >=1",
                   last_nz, u_if.gnt, zero_run);
        end
      end
      last_nz  = u_if.gnt;
      zero_run = 0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    u_if.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (u_if.gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", u_if.gnt); end
      n_cmp++;
      if (u_if.sel !== 2'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", u_if.sel); end
      n_cmp++;
      if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", u_if.busy); end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0001) begin n_err++; $display("FAIL rst_first_gnt: got %b want 0001", u_if.gnt); end
    n_cmp++;
    if (u_if.busy !== 1'b1) begin n_err++; $display("FAIL rst_first_busy: got %b want 1", u_if.busy); end
  endtask

  task automatic test_single();
    do_reset();
    u_if.req = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) u_if.req = 4'b0000;
      n_cmp++;
      if (u_if.gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt t+%0d: got %b want 0100", i, u_if.gnt); end
      n_cmp++;
      if (u_if.sel !== 2'd2) begin n_err++; $display("FAIL single_sel t+%0d: got %0d want 2", i, u_if.sel); end
      n_cmp++;
      if (u_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy t+%0d: got %b want 1", i, u_if.busy); end
    end
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b1) begin
      n_err++; $display("FAIL single_turn: got gnt=%b busy=%b want 0000/1", u_if.gnt, u_if.busy);
    end
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle: got gnt=%b busy=%b want 0000/0", u_if.gnt, u_if.busy);
    end
    n_cmp++;
    if (u_if.sel !== 2'd2) begin n_err++; $display("FAIL single_sel_hold: got %0d want 2", u_if.sel); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    u_if.req = 4'b1111;
    tick();
    for (int o = 0; o < 5; o++) begin
      exp_gnt = 4'b0001 << (o % 4);
      for (int c = 0; c < 8; c++) begin
        n_cmp++;
        if (u_if.gnt !== exp_gnt || u_if.sel !== 2'(o % 4)) begin
          n_err++;
          $display("FAIL rr_owner%0d_c%0d: got gnt=%b sel=%0d want %b/%0d",
                   o, c, u_if.gnt, u_if.sel, exp_gnt, o % 4);
        end
        tick();
      end
      n_cmp++;
      if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b1) begin
        n_err++; $display("FAIL rr_gap%0d: got gnt=%b busy=%b want 0000/1", o, u_if.gnt, u_if.busy);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    do_reset();
    u_if.req = 4'b0010;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        n_cmp++;
        if (u_if.gnt !== 4'b0010) begin
          n_err++; $display("FAIL preempt_r%0d_c%0d: got %b want 0010", r, c, u_if.gnt);
        end
        tick();
      end
      n_cmp++;
      if (u_if.gnt !== 4'b0000) begin n_err++; $display("FAIL preempt_gap%0d: got %b want 0000", r, u_if.gnt); end
      tick();
    end
    n_cmp++;
    if (u_if.gnt !== 4'b0010) begin n_err++; $display("FAIL preempt_regrant: got %b want 0010", u_if.gnt); end
  endtask

  task automatic test_limit_drop();
    do_reset();
    u_if.req = 4'b0001;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) u_if.req = 4'b0000;
      n_cmp++;
      if (u_if.gnt !== 4'b0001) begin n_err++; $display("FAIL limdrop_c%0d: got %b want 0001", c, u_if.gnt); end
      tick();
    end
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b1) begin
      n_err++; $display("FAIL limdrop_turn: got gnt=%b busy=%b want 0000/1", u_if.gnt, u_if.busy);
    end
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b0) begin
      n_err++; $display("FAIL limdrop_idle: got gnt=%b busy=%b want 0000/0", u_if.gnt, u_if.busy);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    u_if.req = 4'b0010;
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0010) begin n_err++; $display("FAIL handoff_own1: got %b want 0010", u_if.gnt); end
    tick();
    u_if.req = 4'b1000;
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b1) begin
      n_err++; $display("FAIL handoff_turn: got gnt=%b busy=%b want 0000/1", u_if.gnt, u_if.busy);
    end
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b1000) begin n_err++; $display("FAIL handoff_gnt: got %b want 1000", u_if.gnt); end
    n_cmp++;
    if (u_if.sel !== 2'd3) begin n_err++; $display("FAIL handoff_sel: got %0d want 3", u_if.sel); end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    u_if.req = 4'b0100;
    tick();
    u_if.req = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0100) begin n_err++; $display("FAIL midrst_pre: got %b want 0100", u_if.gnt); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0000 || u_if.busy !== 1'b0 || u_if.sel !== 2'd0) begin
      n_err++; $display("FAIL midrst_release: got gnt=%b busy=%b sel=%0d want 0000/0/0",
                        u_if.gnt, u_if.busy, u_if.sel);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (u_if.gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_next: got %b want 0001", u_if.gnt); end
  endtask

  initial begin
    u_if.req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_limit_drop();
    test_handoff();
    test_reset_midgrant();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
